// File: rtl/byte_sum_accumulator.sv
// byte_sum_accumulator
// Accumulates a frame of unsigned bytes through an 8-bit add with carry-in 0.
// It counts carry-outs and accepted bytes with saturating counters, then
// presents the frame total on a held valid/ready output handshake.
// The full-width total is {out_carries, out_sum} when out_ovf is clear.
module byte_sum_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sum,
    output logic [CNT_W-1:0] out_carries,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [7:0]       acc;
    logic [7:0]       acc_next;
    logic [CNT_W-1:0] carries;
    logic [CNT_W-1:0] carries_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             ovf;
    logic             ovf_next;

    logic             accept;
    logic [8:0]       add_result;
    logic [CNT_W:0]   carries_inc;
    logic [CNT_W:0]   count_inc;

    // Saturating increment. The MSB of the result flags an increment that was
    // requested while the counter was already pinned at its maximum.
    function automatic logic [CNT_W:0] sat_inc(
        input logic [CNT_W-1:0] value,
        input logic             inc
    );
        logic [CNT_W:0] res;
        if (!inc) begin
            res = {1'b0, value};
        end else if (value == CNT_MAX) begin
            res = {1'b1, value};
        end else begin
            res = {1'b0, value + CNT_ONE};
        end
        return res;
    endfunction

    // The byte adder and counter updates are always computed; the FSM decides
    // whether they are committed.
    assign accept      = in_valid && (state == ACCUM);
    assign add_result  = {1'b0, acc} + {1'b0, in_data};
    assign carries_inc = sat_inc(carries, add_result[8]);
    assign count_inc   = sat_inc(count, 1'b1);

    // Next-state and register-update logic for the ACCUM/HOLD controller.
    always_comb begin
        state_next   = state;
        acc_next     = acc;
        carries_next = carries;
        count_next   = count;
        ovf_next     = ovf;
        unique case (state)
            ACCUM: begin
                if (accept) begin
                    acc_next     = add_result[7:0];
                    carries_next = carries_inc[CNT_W-1:0];
                    count_next   = count_inc[CNT_W-1:0];
                    ovf_next     = ovf | carries_inc[CNT_W] | count_inc[CNT_W];
                    if (in_last) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                // Result transfer clears everything so no partial sum leaks
                // into the next frame.
                if (out_ready) begin
                    state_next   = ACCUM;
                    acc_next     = 8'd0;
                    carries_next = '0;
                    count_next   = '0;
                    ovf_next     = 1'b0;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // State and accumulator registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACCUM;
            acc     <= 8'd0;
            carries <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            carries <= carries_next;
            count   <= count_next;
            ovf     <= ovf_next;
        end
    end

    // Handshake outputs depend on state only, so out_ready never reaches
    // in_ready combinationally.
    assign in_ready    = (state == ACCUM);
    assign out_valid   = (state == HOLD);
    assign out_sum     = acc;
    assign out_carries = carries;
    assign out_count   = count;
    assign out_ovf     = ovf;

endmodule

// File: tb/tb_byte_sum_accumulator.sv
// Self-checking bench for byte_sum_accumulator. Two instances (CNT_W=8 and
// CNT_W=2) share one input stream; a frame-level model predicts both.
module tb_byte_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       rdy8, vld8, ovf8;
    logic [7:0] sum8, car8, cnt8;
    logic       rdy2, vld2, ovf2;
    logic [7:0] sum2;
    logic [1:0] car2, cnt2;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    // Frame-level model: running true total and byte count of the open frame.
    bit m_hold = 1'b0;
    int m_tot = 0;
    int m_n = 0;

    always #5 clk = ~clk;

    byte_sum_accumulator #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data), .in_last(in_last),
        .out_valid(vld8), .out_ready(out_ready),
        .out_sum(sum8), .out_carries(car8), .out_count(cnt8), .out_ovf(ovf8)
    );

    byte_sum_accumulator #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data), .in_last(in_last),
        .out_valid(vld2), .out_ready(out_ready),
        .out_sum(sum2), .out_carries(car2), .out_count(cnt2), .out_ovf(ovf2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Model update: every byte offered while not holding is taken; a taken
    // byte with in_last closes the frame; out_ready in hold empties it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hold = 1'b0;
            m_tot  = 0;
            m_n    = 0;
        end else if (!m_hold) begin
            if (in_valid) begin
                m_tot = m_tot + int'(in_data);
                m_n   = m_n + 1;
                if (in_last) m_hold = 1'b1;
            end
        end else if (out_ready) begin
            m_hold = 1'b0;
            m_tot  = 0;
            m_n    = 0;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            chk("valid8", int'(vld8), int'(m_hold));
            chk("ready8", int'(rdy8), int'(!m_hold));
            chk("sum8", int'(sum8), m_tot % 256);
            chk("carries8", int'(car8), sat(m_tot / 256, 255));
            chk("count8", int'(cnt8), sat(m_n, 255));
            chk("ovf8", int'(ovf8), int'((m_tot / 256 > 255) || (m_n > 255)));
            chk("valid2", int'(vld2), int'(m_hold));
            chk("ready2", int'(rdy2), int'(!m_hold));
            chk("sum2", int'(sum2), m_tot % 256);
            chk("carries2", int'(car2), sat(m_tot / 256, 3));
            chk("count2", int'(cnt2), sat(m_n, 3));
            chk("ovf2", int'(ovf2), int'((m_tot / 256 > 3) || (m_n > 3)));
        end
    end

    // Offer one byte and wait (bounded) until it is accepted; returns at
    // 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!rdy8 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 50) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_valid", int'(vld8), 0);
        chk("rst_ready", int'(rdy8), 1);
        chk("rst_sum", int'(sum8), 0);
        chk("rst_count", int'(cnt8), 0);
        chk("rst_ovf", int'(ovf8), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_cmp = 1'b1;

        // Plain three-byte frame, consumer ready
        out_ready = 1'b1;
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b1);
        chk("t1_valid", int'(vld8), 1);
        chk("t1_sum", int'(sum8), 'h60);
        chk("t1_carries", int'(car8), 0);
        chk("t1_count", int'(cnt8), 3);
        chk("t1_count2", int'(cnt2), 3);
        chk("t1_ovf2", int'(ovf2), 0);
        tick();
        chk("t1_valid_next", int'(vld8), 0);
        chk("t1_ready_next", int'(rdy8), 1);

        // Back-to-back frames, no leakage between them
        send(8'hFF, 1'b0);
        send(8'h02, 1'b1);
        chk("t2a_sum", int'(sum8), 'h01);
        chk("t2a_carries", int'(car8), 1);
        chk("t2a_count", int'(cnt8), 2);
        send(8'h80, 1'b0);
        send(8'h80, 1'b0);
        send(8'h80, 1'b1);
        chk("t2b_sum", int'(sum8), 'h80);
        chk("t2b_carries", int'(car8), 1);
        chk("t2b_count", int'(cnt8), 3);
        tick();

        // Backpressure in HOLD with a byte waiting
        out_ready = 1'b0;
        send(8'h05, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_ready", int'(rdy8), 0);
            chk("t3_valid", int'(vld8), 1);
            chk("t3_sum", int'(sum8), 'h05);
            chk("t3_count", int'(cnt8), 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t3_ready_after", int'(rdy8), 1);
        chk("t3_count_after", int'(cnt8), 0);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("t3_aa_valid", int'(vld8), 1);
        chk("t3_aa_sum", int'(sum8), 'hAA);
        tick();

        // Saturation: six 0xFF bytes
        for (int i = 0; i < 6; i++) send(8'hFF, (i == 5) ? 1'b1 : 1'b0);
        chk("t4_sum2", int'(sum2), 'hFA);
        chk("t4_carries2", int'(car2), 3);
        chk("t4_count2", int'(cnt2), 3);
        chk("t4_ovf2", int'(ovf2), 1);
        chk("t4_carries8", int'(car8), 5);
        chk("t4_count8", int'(cnt8), 6);
        chk("t4_ovf8", int'(ovf8), 0);
        tick();

        // Reset mid-frame in ACCUM
        send(8'h40, 1'b0);
        send(8'h40, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_sum", int'(sum8), 0);
        chk("t5_rst_count", int'(cnt8), 0);
        #2 rst = 1'b0;
        tick();
        send(8'h01, 1'b1);
        chk("t5_sum", int'(sum8), 'h01);
        chk("t5_count", int'(cnt8), 1);
        tick();

        // Reset while holding a result
        out_ready = 1'b0;
        send(8'h40, 1'b0);
        send(8'h40, 1'b1);
        chk("t6_hold_valid", int'(vld8), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_valid", int'(vld8), 0);
        chk("t6_async_ready", int'(rdy8), 1);
        chk("t6_async_sum", int'(sum8), 0);
        chk("t6_async_count", int'(cnt8), 0);
        chk("t6_async_carries", int'(car8), 0);
        #2 rst = 1'b0;
        tick();
        out_ready = 1'b1;
        send(8'h01, 1'b1);
        chk("t6_sum", int'(sum8), 'h01);
        chk("t6_count", int'(cnt8), 1);
        tick();

        // Single zero byte frame
        send(8'h00, 1'b1);
        chk("t7_valid", int'(vld8), 1);
        chk("t7_sum", int'(sum8), 0);
        chk("t7_carries", int'(car8), 0);
        chk("t7_count", int'(cnt8), 1);
        tick();
        chk("t7_valid_next", int'(vld8), 0);

        // Long frame saturating the 8-bit counters
        for (int i = 0; i < 300; i++) send(8'hFF, (i == 299) ? 1'b1 : 1'b0);
        chk("t8_sum8", int'(sum8), 'hD4);
        chk("t8_carries8", int'(car8), 255);
        chk("t8_count8", int'(cnt8), 255);
        chk("t8_ovf8", int'(ovf8), 1);
        tick();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("drain_valid", int'(vld8), 0);

        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
